// File: rtl/video_pkg.sv
// video_pkg: shared video/DDR defaults, derived burst geometry and read-scheduler state type
package video_pkg;
    localparam int DEF_DQ_WIDTH   = 32;
    localparam int DEF_H_WIDTH    = 1280;
    localparam int DEF_H_HEIGHT   = 720;
    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_ADDR_WIDTH = 28;
    localparam logic [27:0] DEF_CH_STRIDE = 28'h0200000;
    localparam int LINE_BYTES  = DEF_H_WIDTH;
    localparam int BURST_BYTES = DEF_BURST_LEN * DEF_DQ_WIDTH;
    localparam int NBURST      = LINE_BYTES / BURST_BYTES;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_BUF, S_ADDR, S_DATA, S_NEXT} state_t;
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rd_addr_gen.sv
// rd_addr_gen: line/half/burst counters producing the quadrant channel and burst byte address
module rd_addr_gen import video_pkg::*; #(
    parameter int H_HEIGHT   = DEF_H_HEIGHT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_B     = LINE_BYTES,
    parameter int BURST_B    = BURST_BYTES,
    parameter int N_BURST    = NBURST,
    parameter logic [ADDR_WIDTH-1:0] CH_STRIDE = ADDR_WIDTH'(DEF_CH_STRIDE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step,
    input  logic                  restart,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [1:0]            ch,
    output logic                  last_burst
);
    localparam int LW = cnt_width(H_HEIGHT);
    localparam int BW = cnt_width(N_BURST);
    localparam logic [LW-1:0] LAST_LINE = LW'(H_HEIGHT - 1);
    localparam logic [LW-1:0] LAST_TOP  = LW'(H_HEIGHT / 2 - 1);
    localparam logic [BW-1:0] LAST_B    = BW'(N_BURST - 1);
    localparam logic [ADDR_WIDTH-1:0] CH_STRIDE2 = CH_STRIDE << 1;

    logic [LW-1:0]         line_q, line_d;
    logic                  half_q, half_d;
    logic                  bottom_q, bottom_d;
    logic [BW-1:0]         bidx_q, bidx_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] off_q, off_d;

    assign ch         = {bottom_q, half_q};
    assign araddr     = (bottom_q ? CH_STRIDE2 : '0) + (half_q ? CH_STRIDE : '0) + row_q + off_q;
    assign last_burst = (line_q == LAST_LINE) && half_q && (bidx_q == LAST_B);

    // Advance burst -> half -> line; row base and burst offset are kept as running sums
    always_comb begin
        line_d   = line_q;
        half_d   = half_q;
        bottom_d = bottom_q;
        bidx_d   = bidx_q;
        row_d    = row_q;
        off_d    = off_q;
        if (restart) begin
            line_d   = '0;
            half_d   = 1'b0;
            bottom_d = 1'b0;
            bidx_d   = '0;
            row_d    = '0;
            off_d    = '0;
        end else if (step && bidx_q != LAST_B) begin
            bidx_d = bidx_q + BW'(1);
            off_d  = off_q + ADDR_WIDTH'(BURST_B);
        end else if (step) begin
            bidx_d = '0;
            off_d  = '0;
            half_d = ~half_q;
            if (half_q) begin
                line_d   = (line_q == LAST_LINE) ? '0 : line_q + LW'(1);
                bottom_d = (line_q == LAST_TOP) ? 1'b1 : (line_q == LAST_LINE) ? 1'b0 : bottom_q;
                row_d    = (line_q == LAST_TOP || line_q == LAST_LINE) ? '0 : row_q + ADDR_WIDTH'(LINE_B);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q   <= '0;
            half_q   <= 1'b0;
            bottom_q <= 1'b0;
            bidx_q   <= '0;
            row_q    <= '0;
            off_q    <= '0;
        end else begin
            line_q   <= line_d;
            half_q   <= half_d;
            bottom_q <= bottom_d;
            bidx_q   <= bidx_d;
            row_q    <= row_d;
            off_q    <= off_d;
        end
    end
endmodule

// File: rtl/ddr_rd_sched.sv
// ddr_rd_sched: issues one AXI read burst at a time to assemble a 2x2 channel mosaic into the HDMI buffer
module ddr_rd_sched import video_pkg::*; #(
    parameter int DQ_WIDTH   = DEF_DQ_WIDTH,
    parameter int H_WIDTH    = DEF_H_WIDTH,
    parameter int H_HEIGHT   = DEF_H_HEIGHT,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] CH_STRIDE = ADDR_WIDTH'(DEF_CH_STRIDE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  buf_wait,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic                  axi_rvalid,
    input  logic                  axi_rlast,
    output logic                  axi_rready,
    output logic                  buf_wr_en,
    output logic [1:0]            channel_sel,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int LINE_B  = H_WIDTH;
    localparam int BURST_B = BURST_LEN * DQ_WIDTH;
    localparam int N_BURST = LINE_B / BURST_B;

    if ((LINE_B % BURST_B) != 0 || N_BURST < 1 || (H_HEIGHT % 2) != 0 || BURST_LEN > 256) begin : g_bad_cfg
        $error("ddr_rd_sched: half-line must be a whole number of bursts and height must be even");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  resync_q, resync_d;
    logic                  step, restart, last_burst;
    logic [ADDR_WIDTH-1:0] gen_araddr;
    logic [1:0]            gen_ch;

    rd_addr_gen #(
        .H_HEIGHT  (H_HEIGHT),
        .ADDR_WIDTH(ADDR_WIDTH),
        .LINE_B    (LINE_B),
        .BURST_B   (BURST_B),
        .N_BURST   (N_BURST),
        .CH_STRIDE (CH_STRIDE)
    ) u_gen (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .restart   (restart),
        .araddr    (gen_araddr),
        .ch        (gen_ch),
        .last_burst(last_burst)
    );

    assign axi_araddr  = araddr_q;
    assign axi_arlen   = 8'(BURST_LEN - 1);
    assign axi_arvalid = arvalid_q;
    assign axi_rready  = rready_q;
    assign buf_wr_en   = axi_rvalid & axi_rready;
    assign channel_sel = gen_ch;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

    // Burst sequencing FSM; a frame_start during a frame is deferred to the next burst boundary
    always_comb begin
        state_d      = state_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        resync_d     = resync_q | (frame_start & busy_q);
        step         = 1'b0;
        restart      = 1'b0;
        case (state_q)
            S_IDLE: if (frame_start) begin
                restart = 1'b1;
                busy_d  = 1'b1;
                state_d = S_WAIT_BUF;
            end
            S_WAIT_BUF: if (!buf_wait) begin
                araddr_d  = gen_araddr;
                arvalid_d = 1'b1;
                state_d   = S_ADDR;
            end
            S_ADDR: if (axi_arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = S_DATA;
            end
            S_DATA: if (axi_rvalid && axi_rlast) begin
                rready_d = 1'b0;
                state_d  = S_NEXT;
            end
            S_NEXT: begin
                resync_d = 1'b0;
                state_d  = S_WAIT_BUF;
                if (resync_q || frame_start) begin
                    restart = 1'b1;
                end else begin
                    step = 1'b1;
                    if (last_burst) begin
                        frame_done_d = 1'b1;
                        busy_d       = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered AXI/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            resync_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            resync_q     <= resync_d;
        end
    end
endmodule

// File: doc/ddr_rd_sched.md
Name: ddr_rd_sched

Overview:
- Sequences AXI4 read bursts from the four per-channel DDR frame regions into the HDMI read buffer, so the buffer receives a 2x2 quadrant mosaic in raster order.
- Sits between the DDR AXI read port and ddr_rd_buf, in the single DDR user clock domain.
- Per output line it fetches the left half-line and then the right half-line:
  - output lines 0..V/2-1: channel 0, then channel 1;
  - output lines V/2..V-1: channel 2, then channel 3.
- Drives channel_sel to ddr_rd_buf and throttles on its axi_wr_buf_wait.

Parameters:
- DQ_WIDTH, 32: DDR DQ width in bits; AXI beat = DQ_WIDTH*8 bits = DQ_WIDTH bytes.
- H_WIDTH, 1280: output line width in pixels.
- H_HEIGHT, 720: output frame height in lines.
- BURST_LEN, 8: beats per AXI read burst.
- ADDR_WIDTH, 28: AXI byte address width.
- CH_STRIDE, 28'h0200000: byte offset between channel frame regions; channel n base = n*CH_STRIDE.

Ports:
- clk, input, 1: DDR user clock.
- rst, input, 1: synchronous reset, active-high.
- frame_start, input, 1: one-cycle pulse (HDMI vsync already in clk domain) that starts a frame fetch.
- buf_wait, input, 1: from ddr_rd_buf axi_wr_buf_wait; 1 = buffer cannot accept a further burst.
- axi_araddr, output, ADDR_WIDTH: read burst byte address.
- axi_arlen, output, 8: constant BURST_LEN-1.
- axi_arvalid, output, 1: address valid.
- axi_arready, input, 1: address accepted.
- axi_rvalid, input, 1: read data valid.
- axi_rlast, input, 1: last beat of the burst.
- axi_rready, output, 1: read data ready.
- buf_wr_en, output, 1: axi_rvalid & axi_rready; data is routed straight to ddr_rd_buf buf_wr_data.
- channel_sel, output, 2: channel whose data is currently flowing.
- busy, output, 1: 1 while a frame is in progress.
- frame_done, output, 1: one-cycle pulse after the last burst of the frame completes.

Behaviour:
- Reset: every output is 0, state = IDLE, and all counters are 0. axi_arlen is the constant BURST_LEN-1 and is exempt.
- Derived constants:
  - LINE_BYTES = H_WIDTH, i.e. a source half-line of H_WIDTH/2 pixels at 2 bytes each.
  - BURST_BYTES = BURST_LEN*DQ_WIDTH.
  - NBURST = LINE_BYTES/BURST_BYTES, which is 5 with the defaults. A compile-time check fails if the division is not exact.
- Counters:
  - line, 0..H_HEIGHT-1.
  - half, 0..1.
  - bidx, 0..NBURST-1.
- Channel and source row:
  - ch = {line >= H_HEIGHT/2, half}.
  - r = line mod H_HEIGHT/2.
- Address: axi_araddr = ch*CH_STRIDE + r*LINE_BYTES + bidx*BURST_BYTES, registered on entry to ADDR and held stable until the handshake.
- FSM states and transitions:
  - IDLE: on frame_start, clear counters, set busy=1, go to WAIT_BUF.
  - WAIT_BUF: if buf_wait=0, go to ADDR next cycle; otherwise stay.
  - ADDR: axi_arvalid=1. Address and arvalid do not change until axi_arvalid & axi_arready; then arvalid=0 and go to DATA.
  - DATA: axi_rready=1. When rvalid & rlast, go to NEXT.
  - NEXT: increment bidx, wrapping into half, then into line.
    - If the frame is complete: frame_done=1 for one cycle, busy=0, go to IDLE.
    - Otherwise go to WAIT_BUF.
- channel_sel is updated in NEXT, or in IDLE on frame start. It is therefore stable through WAIT_BUF/ADDR/DATA and always equals ch of the burst in flight.
- Latency: frame_start at cycle N with buf_wait=0 gives axi_arvalid=1 at cycle N+2. Burst-to-burst gap is 3 cycles minimum (NEXT, WAIT_BUF, ADDR).
- Only one burst is outstanding at a time; no new AR is issued before the rlast of the previous burst.
- buf_wait changes:
  - Sampled only in WAIT_BUF.
  - Assertion during ADDR or DATA does not abort the burst; the buffer must have headroom of at least BURST_LEN beats.
- frame_start while busy:
  - Set a resync flag.
  - The current burst completes normally.
  - In NEXT, if resync is set: clear counters, set channel_sel=0, clear the flag, go to WAIT_BUF. frame_done is not pulsed.
- frame_start in the same cycle as the final NEXT: treated as a restart; frame_done is suppressed and busy stays 1.
- rst asserted mid-burst: immediate return to the reset state. AXI-side recovery is the interconnect's concern, since rst resets the whole DDR domain.
- Arithmetic: the address is computed in ADDR_WIDTH bits, with ch*CH_STRIDE done as a shift when CH_STRIDE is a power of two.
  - r*LINE_BYTES is computed as an incrementing row-base register: += LINE_BYTES per source row, reset at line H_HEIGHT/2. No multiplier.

Decomposition:
- Shared package video_pkg:
  - H_WIDTH, H_HEIGHT, DQ_WIDTH, BURST_LEN, CH_STRIDE defaults.
  - The FSM state typedef.
  - Derived LINE_BYTES, BURST_BYTES, NBURST.
- Sub-module rd_addr_gen: owns the line/half/bidx counters, the row-base register, channel and address generation. Interface: step, restart, araddr, ch, last_burst.
- The top module holds the FSM and the AXI handshake logic.

Test Plan:
- Reset, then frame_start with buf_wait=0, arready=1, and a slave model with 1-cycle rvalid latency:
  - First AR at cycle N+2: addr 0x0000000, arlen=7, channel_sel=0.
  - Next ARs: 0x100, 0x200, 0x300, 0x400.
  - Then the channel 1 half at 0x0200000, with channel_sel=1 while its data flows.
- Line 360 (first bottom line): first AR 0x0400000 with channel_sel=2, then 0x0600000 with channel_sel=3.
- Line 719: channel 3 last burst at 0x0600000+359*1280+0x400. After its rlast, frame_done=1 for exactly one cycle and busy drops. Exactly 720*2*5 = 7200 ARs in total.
- Hold buf_wait=1 for 50 cycles before the third burst: no arvalid during the hold; AR issues 2 cycles after buf_wait falls; address unchanged.
- arready held low 10 cycles: araddr and arvalid remain stable until the handshake.
- frame_start mid-burst (line 100): the burst completes with all 8 buf_wr_en beats; the next AR is 0x0000000 with channel_sel=0; no frame_done pulse.
